// File: rtl/pkt_serializer.sv
// Byte FIFO feeding an LSB-first serializer with a programmable idle gap between bytes.
// Bytes queue while link_up=0 and drain back-to-back (plus gap) while link_up=1.
module pkt_serializer #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_50,
    input  logic                     reset_n,
    input  logic [7:0]               byte_in,
    input  logic                     byte_wr,
    input  logic                     link_up,
    input  logic [7:0]               gap_cycles,
    output logic                     serial_data,
    output logic                     data_ena,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_full,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(0);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_ovf;

    logic [1:0]    r_state;
    logic [7:0]    r_shreg;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_gapcnt;
    logic          r_serial;
    logic          r_ena;

    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [AW:0]   w_count_nxt;
    logic [7:0]    w_gap_load;

    // Push/pop decisions; the pop only ever looks at the registered count, so a byte
    // pushed this edge cannot also be popped this edge.
    always_comb begin
        w_push  = byte_wr & ~r_full;
        w_empty = (r_count == CNT_ZERO);
        w_pop   = 1'b0;
        case (r_state)
            ST_IDLE: w_pop = link_up & ~w_empty;
            ST_GAP:  w_pop = link_up & ~w_empty & (r_gapcnt == 8'd1);
            default: w_pop = 1'b0;
        endcase
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_ONE;
        end else begin
            w_count_nxt = r_count;
        end
        if (gap_cycles == 8'd0) begin
            w_gap_load = 8'd1;
        end else begin
            w_gap_load = gap_cycles;
        end
    end

    // Byte storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_50) begin
        if (reset_n && w_push) begin
            r_mem[r_wptr] <= byte_in;
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= CNT_ZERO;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_DEPTH);
            if (byte_wr && r_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Serializer FSM; outputs are registered from the current state, so they trail
    // the state by one edge (pop at N+1, first bit visible from N+2).
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_shreg  <= 8'd0;
            r_bitcnt <= 3'd0;
            r_gapcnt <= 8'd0;
            r_serial <= 1'b0;
            r_ena    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_serial <= 1'b0;
                    r_ena    <= 1'b0;
                    if (w_pop) begin
                        r_shreg  <= r_mem[r_rptr];
                        r_bitcnt <= 3'd0;
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_serial <= r_shreg[0];
                    r_ena    <= 1'b1;
                    r_shreg  <= {1'b0, r_shreg[7:1]};
                    r_bitcnt <= r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        r_gapcnt <= w_gap_load;
                        r_state  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    r_serial <= 1'b0;
                    r_ena    <= 1'b0;
                    if (r_gapcnt == 8'd1) begin
                        if (w_pop) begin
                            r_shreg  <= r_mem[r_rptr];
                            r_bitcnt <= 3'd0;
                            r_state  <= ST_SHIFT;
                        end else begin
                            r_state  <= ST_IDLE;
                        end
                    end else begin
                        r_gapcnt <= r_gapcnt - 8'd1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_serial <= 1'b0;
                    r_ena    <= 1'b0;
                end
            endcase
        end
    end

    assign serial_data = r_serial;
    assign data_ena    = r_ena;
    assign fifo_count  = r_count;
    assign fifo_full   = r_full;
    assign overflow    = r_ovf;

endmodule

// File: doc/pkt_serializer.md
PKT_SERIALIZER -- requirements
Module: pkt_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, byte FIFO depth (power of 2, >=2).
REQ-002 SHALL have port clk_50  input  1  50 MHz clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port byte_in  input  8  byte to queue for transmission.
REQ-005 SHALL have port byte_wr  input  1  push strobe; byte_in captured on the same edge.
REQ-006 SHALL have port link_up  input  1  1 = light side, transmission allowed; 0 = dark side, bytes queue.
REQ-007 SHALL have port gap_cycles  input  8  idle cycles between bytes; 0 treated as 1.
REQ-008 SHALL have port serial_data  output  1  serial bit to downstream averager, LSB first.
REQ-009 SHALL have port data_ena  output  1  high while a byte's 8 bits are on serial_data.
REQ-010 SHALL have port fifo_count  output  log2(DEPTH)+1  bytes currently queued.
REQ-011 SHALL have port fifo_full  output  1  fifo_count == DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky; a push was dropped.

Function
REQ-013 SHALL accept a push only when fifo_full=0; a push while full is dropped and sets overflow, even if a pop occurs on the same edge.
REQ-014 SHALL clear overflow only by reset.
REQ-015 SHALL update fifo_count on the edge after a push or pop; simultaneous accepted push and pop leave it unchanged.
REQ-016 SHALL wrap FIFO read/write pointers modulo DEPTH and preserve byte order.
REQ-017 SHALL implement FSM states IDLE, SHIFT, GAP; all outputs registered.
REQ-018 IDLE: serial_data=0, data_ena=0; when link_up=1 and fifo_count>0, pop head byte into shift register and enter SHIFT on the same edge.
REQ-019 SHALL drive, in SHIFT, data_ena=1 for exactly 8 consecutive cycles with serial_data = bit 0, 1, ..., 7 of the popped byte.
REQ-020 SHALL enter GAP after bit 7, driving data_ena=0, serial_data=0 for max(gap_cycles,1) cycles; gap_cycles sampled on entry to GAP.
REQ-021 SHALL, on the last GAP cycle, pop and return directly to SHIFT if link_up=1 and FIFO non-empty, else go to IDLE; no extra idle cycle.
REQ-022 First bit latency: byte pushed into empty FIFO at edge N with link_up=1 in IDLE -> data_ena=1 from edge N+2.
REQ-023 SHALL never truncate a byte: link_up falling during SHIFT or GAP completes the current byte and gap, then holds in IDLE.
REQ-024 SHALL hold queued bytes indefinitely while link_up=0.
REQ-025 A push to an empty FIFO on the same edge IDLE would pop is not visible until the following cycle.

Reset
REQ-026 SHALL, on any edge with reset_n=0, force state IDLE, serial_data=0, data_ena=0, fifo_count=0, fifo_full=0, overflow=0, pointers and bit counter to 0.
REQ-027 SHALL abandon a byte in flight on reset mid-SHIFT; data_ena=0 from the first reset edge.
REQ-028 SHALL ignore byte_wr while reset_n=0.

Verification
REQ-029 link_up=1, gap 1, push 8'hA5 -> data_ena high 8 cycles, serial_data 1,0,1,0,0,1,0,1, then data_ena low.
REQ-030 link_up=0, push A5,0A,14,1E,28, then raise link_up, gap 1 -> five bytes in order, 8 high/1 low cycles each, 44 cycles first bit to last bit.
REQ-031 DEPTH=16, link_up=0, push 17 bytes -> fifo_full=1 after 16th, overflow=1, 17th dropped; after link_up=1 exactly 16 bytes sent, fifo_count=0.
REQ-032 gap_cycles=200, two queued bytes -> data_ena low exactly 200 cycles between them; gap_cycles=0 -> exactly 1.
REQ-033 link_up dropped at bit 3 of byte 1 with 2 queued -> byte 1 completes all 8 bits, byte 2 held until link_up=1, then sent.
REQ-034 reset_n=0 at bit 4 with 3 queued -> next edge data_ena=0, fifo_count=0, overflow=0; after release nothing transmitted.
